// File: rtl/striping_pkg.sv
// Shared definitions for the lane-striping demultiplexer: group counter width,
// lane-count decode with illegal-value fallback, and flat-bus slice indexing.
package striping_pkg;

    localparam int GROUP_CNT_W = 16;

    // Legal lane counts are nonzero powers of two not exceeding the physical lane count.
    function automatic logic [31:0] decode_lanes(input logic [31:0] lanes_active,
                                                 input logic [31:0] num_lanes);
        if ((lanes_active != 32'd0) &&
            ((lanes_active & (lanes_active - 32'd1)) == 32'd0) &&
            (lanes_active <= num_lanes)) begin
            return lanes_active;
        end
        return num_lanes;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/striping_lane_ptr.sv
// Lane slot pointer: wraps at the effective lane count and latches the lane
// configuration so that a change only lands on a group boundary.
module striping_lane_ptr
    import striping_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = 2
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [PTR_W:0]   lanes_active_i,
    input  logic             valid_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic [PTR_W:0]   act_o,
    output logic             last_slot_o,
    output logic             at_zero_o
);

    localparam int ACT_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [ACT_W-1:0] act_q;
    logic [ACT_W-1:0] act;
    logic [31:0]      lanes_ext;

    assign lanes_ext = 32'(lanes_active_i);
    assign at_zero_o = (ptr_q == '0);

    // Mid-group the latched count is used, so a new request waits for slot 0.
    assign act = at_zero_o ? ACT_W'(decode_lanes(lanes_ext, 32'(NUM_LANES))) : act_q;

    assign last_slot_o = ({1'b0, ptr_q} == (act - ACT_W'(1)));
    assign ptr_o       = ptr_q;
    assign act_o       = act;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ptr_d = '0;
        if (valid_i && !last_slot_o) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            ptr_q <= '0;
            act_q <= ACT_W'(NUM_LANES);
        end else begin
            ptr_q <= ptr_d;
            act_q <= act;
        end
    end

endmodule

// File: rtl/demux_striping_n.sv
// Round-robin word striper: stages words per lane and presents a whole group
// on all active lanes at once, flushing partial groups on an idle cycle.
module demux_striping_n
    import striping_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_LANES  = 4,
    localparam int PTR_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk_2f,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           data_input,
    input  logic                            valid_in,
    input  logic [PTR_W:0]                  lanes_active,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    output logic [NUM_LANES-1:0]            valid_out,
    output logic [GROUP_CNT_W-1:0]          groups_sent
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   act;
    logic             last_slot;
    logic             at_zero;

    striping_lane_ptr #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_lane_ptr (
        .clk_2f         (clk_2f),
        .reset          (reset),
        .lanes_active_i (lanes_active),
        .valid_i        (valid_in),
        .ptr_o          (ptr),
        .act_o          (act),
        .last_slot_o    (last_slot),
        .at_zero_o      (at_zero)
    );

    logic [DATA_WIDTH-1:0]           stage_q [NUM_LANES];
    logic [DATA_WIDTH-1:0]           stage_d [NUM_LANES];
    logic [NUM_LANES-1:0]            stage_v_q;
    logic [NUM_LANES-1:0]            stage_v_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_d;
    logic [NUM_LANES-1:0]            valid_out_q;
    logic [NUM_LANES-1:0]            valid_out_d;
    logic [GROUP_CNT_W-1:0]          groups_q;
    logic [GROUP_CNT_W-1:0]          groups_d;

    logic emit_full;
    logic emit_flush;

    assign emit_full  = valid_in && last_slot;
    assign emit_flush = !valid_in && !at_zero;

    always_comb begin
        stage_d     = stage_q;
        stage_v_d   = stage_v_q;
        lane_data_d = lane_data_q;
        valid_out_d = '0;
        groups_d    = groups_q;

        if (valid_in) begin
            stage_d[ptr]   = data_input;
            stage_v_d[ptr] = 1'b1;
        end

        if (emit_full) begin
            // The closing word bypasses staging so the group leaves on this edge.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (i == int'(ptr)) begin
                    lane_data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = data_input;
                end else if (i < int'(act)) begin
                    lane_data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = stage_q[i];
                end else begin
                    lane_data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = '0;
                end
                valid_out_d[i] = (i < int'(act));
            end
            stage_v_d = '0;
            groups_d  = groups_q + GROUP_CNT_W'(1);
        end else if (emit_flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
                    stage_v_q[i] ? stage_q[i] : '0;
            end
            valid_out_d = stage_v_q;
            stage_v_d   = '0;
            groups_d    = groups_q + GROUP_CNT_W'(1);
        end
    end

    // NOTE: the staging array is reset explicitly so no stale word can ever reach a lane.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                stage_q[i] <= '0;
            end
            stage_v_q   <= '0;
            lane_data_q <= '0;
            valid_out_q <= '0;
            groups_q    <= '0;
        end else begin
            stage_q     <= stage_d;
            stage_v_q   <= stage_v_d;
            lane_data_q <= lane_data_d;
            valid_out_q <= valid_out_d;
            groups_q    <= groups_d;
        end
    end

    assign lane_data   = lane_data_q;
    assign valid_out   = valid_out_q;
    assign groups_sent = groups_q;

endmodule

// File: tb/tb_demux_striping_n.sv
// Scoreboard bench for demux_striping_n: a word-list reference model predicts
// each emitted group and the cycle it appears; a negedge monitor compares.
module tb_demux_striping_n;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam int PW = 2;

    logic               clk_2f       = 1'b0;
    logic               reset        = 1'b1;
    logic               valid_in     = 1'b0;
    logic [DW-1:0]      data_input   = '0;
    logic [PW:0]        lanes_active = 3'd4;
    logic [NL*DW-1:0]   lane_data;
    logic [NL-1:0]      valid_out;
    logic [15:0]        groups_sent;

    demux_striping_n #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL)
    ) dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .data_input   (data_input),
        .valid_in     (valid_in),
        .lanes_active (lanes_active),
        .lane_data    (lane_data),
        .valid_out    (valid_out),
        .groups_sent  (groups_sent)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        int               due;
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    mask;
        logic [15:0]      cnt;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] pend[$];
    int            grp_act  = NL;
    logic [15:0]   m_cnt    = '0;
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cur_la   = 4;

    always @(posedge clk_2f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int model_decode(input int la);
        if (la == 1 || la == 2 || la == 4) return la;
        return NL;
    endfunction

    // Emit whatever words are pending as one group, visible after the coming edge.
    task automatic emit();
        exp_t e;
        e.due  = cyc + 1;
        e.data = '0;
        for (int i = 0; i < pend.size(); i++) e.data[i*DW +: DW] = pend[i];
        e.mask = NL'((1 << pend.size()) - 1);
        m_cnt  = m_cnt + 16'd1;
        e.cnt  = m_cnt;
        sb.push_back(e);
        pend.delete();
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input int la, input bit rst);
        @(negedge clk_2f);
        valid_in     = v;
        data_input   = d;
        lanes_active = 3'(la);
        reset        = rst;
        if (rst) begin
            pend.delete();
            m_cnt = '0;
        end else begin
            if (pend.size() == 0) grp_act = model_decode(la);
            if (v) begin
                pend.push_back(d);
                if (pend.size() == grp_act) emit();
            end else if (pend.size() != 0) begin
                emit();
            end
        end
    endtask

    always @(negedge clk_2f) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("group valid_out", valid_out, e.mask);
            check("group lane_data", lane_data, e.data);
            check("group groups_sent", groups_sent, e.cnt);
        end else begin
            check("idle valid_out", valid_out, '0);
        end
    end

    initial begin
        step(0, '0, 4, 1);
        step(0, '0, 4, 0);
        check("reset lane_data", lane_data, '0);
        check("reset valid_out", valid_out, '0);
        check("reset groups_sent", groups_sent, '0);

        // Full group x4.
        for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 4, 0);
        step(0, '0, 4, 0);
        check("full lane_data", lane_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check("full valid_out", valid_out, 4'b1111);
        check("full groups_sent", groups_sent, 16'd1);

        // Partial flush.
        step(1, 32'hB0, 4, 0);
        step(1, 32'hB1, 4, 0);
        step(0, '0, 4, 0);
        step(0, '0, 4, 0);
        check("flush lane_data", lane_data, {32'h0, 32'h0, 32'hB1, 32'hB0});
        check("flush valid_out", valid_out, 4'b0011);

        // Lane-count change mid-group.
        step(1, 32'h90, 4, 0);
        step(1, 32'h91, 4, 0);
        step(1, 32'h92, 2, 0);
        step(1, 32'h93, 2, 0);
        step(1, 32'hC0, 2, 0);
        step(1, 32'hC1, 2, 0);
        step(0, '0, 2, 0);
        check("cfg lane_data", lane_data, {32'h0, 32'h0, 32'hC1, 32'hC0});
        check("cfg valid_out", valid_out, 4'b0011);

        // x1 back-to-back.
        step(1, 32'hD0, 1, 0);
        step(1, 32'hD1, 1, 0);
        step(0, '0, 1, 0);
        check("x1 lane_data", lane_data, {32'h0, 32'h0, 32'h0, 32'hD1});
        check("x1 valid_out", valid_out, 4'b0001);

        // Reset after three of four words.
        for (int i = 0; i < 3; i++) step(1, 32'hE0 + i, 4, 0);
        step(0, '0, 4, 1);
        step(0, '0, 4, 0);
        check("midreset lane_data", lane_data, '0);
        check("midreset valid_out", valid_out, '0);
        check("midreset groups_sent", groups_sent, '0);
        step(0, '0, 4, 0);

        // Illegal lane count behaves as four lanes.
        for (int i = 0; i < 4; i++) step(1, 32'hF0 + i, 3, 0);
        step(0, '0, 3, 0);
        check("illegal valid_out", valid_out, 4'b1111);

        // Randomised traffic with lane changes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 2) cur_la = $urandom_range(0, 7);
            step($urandom_range(0, 9) < 7, $urandom, cur_la, $urandom_range(0, 199) == 0);
        end

        // Drive the group counter to 0xFFFF, then one more emission wraps it.
        step(0, '0, 1, 1);
        while (m_cnt != 16'hFFFF) step(1, $urandom, 1, 0);
        step(1, 32'hF00D, 1, 0);
        step(0, '0, 1, 0);
        check("wrap groups_sent", groups_sent, 16'h0000);
        check("wrap lane_data", lane_data, {96'h0, 32'hF00D});

        for (int i = 0; i < 4; i++) step(0, '0, 4, 0);
        check("scoreboard drained", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_striping_n.md
# demux_striping_n

Parametrised byte-striping demultiplexer for the PCIe physical-layer transmit path, running in the `clk_2f` domain ahead of the per-lane serialisers. Incoming words are distributed round-robin across a runtime-selectable number of active lanes (x1/x2/x4/...). A complete stripe group is presented on all active lanes in the same cycle, so downstream lanes stay word-aligned. An idle cycle flushes a partial group, and a wrapping group counter supports link monitoring.

## Interface
- `DATA_WIDTH`, 32: width of each word and of each lane.
- `NUM_LANES`, 4: physical lane count; a power of two, 1 to 16.
- `PTR_W`, `$clog2(NUM_LANES)` (min 1): lane pointer width; derived, not overridden.
- `clk_2f`  in  1: single clock; all state on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data_input`  in  DATA_WIDTH: word to stripe.
- `valid_in`  in  1: `data_input` is valid this cycle.
- `lanes_active`  in  PTR_W+1: requested active lane count. Legal values are powers of two ≤ `NUM_LANES`; any other value is treated as `NUM_LANES`.
- `lane_data`  out  NUM_LANES*DATA_WIDTH: flat lane bus; lane i is bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_out`  out  NUM_LANES: per-lane valid, one-cycle pulse per emitted group.
- `groups_sent`  out  16: count of emitted groups, full or partial.

## Operation
- State:
  - `ptr`: next lane slot.
  - `stage[NUM_LANES]`: staging words.
  - `stage_v`: filled-slot mask.
  - `act_q`: latched active lane count.
- Effective lane count `act` = decoded `lanes_active` when `ptr==0`, else `act_q`.
  - `act_q <= act` every cycle.
  - A lane-count change therefore takes effect only at a group boundary, never mid-group.
- Accept (`valid_in==1`):
  - `stage[ptr] <= data_input` and `stage_v[ptr] <= 1`.
  - If `ptr == act-1`: emit a full group. `lane_data` loads all staged words with the current word in slot `ptr`; `valid_out` = low `act` bits set; `ptr <= 0`; `stage_v <= 0`.
  - Otherwise `ptr <= ptr+1`.
- Flush (`valid_in==0` and `ptr!=0`):
  - Emit a partial group. Filled slots go to their lanes; unfilled lanes load 0.
  - `valid_out = stage_v`; `ptr <= 0`; `stage_v <= 0`.
- Idle (`valid_in==0` and `ptr==0`): `valid_out <= 0`; `lane_data` holds its last value.
- Lanes ≥ `act` always load 0 and keep `valid_out` low on every emission.
- `groups_sent` increments by 1 on each emission and wraps 0xFFFF→0x0000.
- `act==1`: every valid word is emitted on lane 0 alone; `valid_out` = 0…01.

## Timing
- Reset:
  - `lane_data`=0, `valid_out`=0, `groups_sent`=0.
  - `ptr`=0, `stage`=0, `stage_v`=0, `act_q`=`NUM_LANES`.
  - `reset` overrides `valid_in` on the same edge.
- Reset mid-group discards staged words with no emission.
- Latency: a group is visible the cycle after the edge that accepts its last word, or the cycle after its flush edge.
- `valid_out` is high for exactly one cycle per group. Back-to-back groups give consecutive `valid_out` pulses with no gap.
- No backpressure: the block accepts a word every cycle.
- Flush costs one idle cycle. A word arriving the cycle after a flush starts a new group at lane 0.

## Structure
- Shared package `striping_pkg`:
  - `decode_lanes(lanes_active)` function, including the illegal-value fallback to `NUM_LANES`.
  - Group counter width constant (16).
  - Lane-slice helper for the flat-bus index.
- Sub-module `striping_lane_ptr`: pointer counter with `act` wrap, group-boundary config latch, and last-slot / at-zero flags.
- The top level holds the staging array, output registers and `groups_sent`.

## Test plan
- Full groups: `NUM_LANES`=4, `lanes_active`=4, words 0xA0..0xA3 on cycles 0–3 → cycle 4: lanes 0–3 = A0,A1,A2,A3; `valid_out`=4'b1111; `groups_sent`=1; cycle 5: `valid_out`=0.
- Partial flush: words 0xB0,0xB1, then `valid_in`=0 → next cycle: lanes 0,1 = B0,B1; lanes 2,3 = 0; `valid_out`=4'b0011.
- Config change mid-group: `lanes_active` goes 4→2 after word 1 of a 4-word stream → first group still emits 4 lanes; next words C0,C1 emit as `valid_out`=4'b0011.
- x1 mode plus reset mid-group:
  - `lanes_active`=1, words D0,D1 back-to-back → lane 0 = D0 then D1 on consecutive cycles, `valid_out`=0001 both cycles.
  - Separately: `reset` after 3 of 4 words → no emission, all outputs 0.
- Illegal `lanes_active`=3 → behaves as 4 lanes. Preload 0xFFFF groups → next emission wraps `groups_sent` to 0.
